// File: rtl/zx_line_doubler.sv
// ZX Spectrum scandoubler: captures RGBI lines at 7 MHz into a ping-pong buffer and
// replays each one twice at 14 MHz as RGB222 with regenerated syncs and lock detection.
module zx_line_doubler #(
  parameter int unsigned LINE_CLKS   = 896,
  parameter int unsigned CAP_START   = 64,
  parameter int unsigned ACTIVE_W    = 312,
  parameter int unsigned H_START     = 89,
  parameter int unsigned HSYNC_START = 10,
  parameter int unsigned HSYNC_WIDTH = 52,
  parameter int unsigned V_START     = 109,
  parameter int unsigned VSYNC_START = 74,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned LOCK_LINES  = 4,
  parameter int unsigned TOL         = 8
) (
  input  logic       ZX_14M,
  input  logic       RESET_N,
  input  logic       ZX_R,
  input  logic       ZX_G,
  input  logic       ZX_B,
  input  logic       ZX_I,
  input  logic       ZX_HSYNC,
  input  logic       ZX_VSYNC,
  input  logic       SCANLINE,
  output logic [1:0] VGA_R,
  output logic [1:0] VGA_G,
  output logic [1:0] VGA_B,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic       LOCKED
);

  localparam int unsigned AW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int unsigned CW = $clog2(LOCK_LINES + 1);

  localparam logic [9:0]    HalfLine = 10'(LINE_CLKS / 2);
  localparam logic [9:0]    LastH    = 10'(LINE_CLKS - 1);
  localparam logic [9:0]    GoodMin  = 10'(LINE_CLKS - 1 - TOL);
  localparam logic [9:0]    CapStart = 10'(CAP_START);
  localparam logic [9:0]    CapLen   = 10'(2 * ACTIVE_W);
  localparam logic [9:0]    HStart   = 10'(H_START);
  localparam logic [9:0]    ActW     = 10'(ACTIVE_W);
  localparam logic [9:0]    HsStart  = 10'(HSYNC_START);
  localparam logic [9:0]    HsEnd    = 10'(HSYNC_START + HSYNC_WIDTH);
  localparam logic [9:0]    VStart   = 10'(V_START);
  localparam logic [9:0]    VsStart  = 10'(VSYNC_START);
  localparam logic [9:0]    VsEnd    = 10'(VSYNC_START + VSYNC_LINES);
  localparam logic [CW-1:0] LockMax  = CW'(LOCK_LINES);

  // [0] first sync flop, [1] second sync flop, [2] previous synchronised value
  logic [2:0] hs_sync_q, vs_sync_q;
  logic       hs_fall, vs_fall;

  always_ff @(posedge ZX_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_sync_q <= '1;
      vs_sync_q <= '1;
    end else begin
      hs_sync_q <= {hs_sync_q[1:0], ZX_HSYNC};
      vs_sync_q <= {vs_sync_q[1:0], ZX_VSYNC};
    end
  end

  assign hs_fall = hs_sync_q[2] & ~hs_sync_q[1];
  assign vs_fall = vs_sync_q[2] & ~vs_sync_q[1];

  // Line position, lock tracking, bank select and vertical position
  logic [9:0]    zx_h_q, zx_h_d;
  logic [9:0]    vga_v_q, vga_v_d;
  logic [CW-1:0] good_q, good_d;
  logic          wr_bank_q, vsync_pend_q, vsync_pend_d;
  logic          miss, vga_wrap, half, locked;
  logic [9:0]    vga_h;

  always_comb begin
    zx_h_d = zx_h_q + 10'd1;
    miss   = 1'b0;
    if (hs_fall) begin
      zx_h_d = '0;
    end else if (zx_h_q == LastH) begin
      zx_h_d = '0;
      miss   = 1'b1;
    end
  end

  always_comb begin
    good_d = good_q;
    if (hs_fall) begin
      if (zx_h_q >= GoodMin) begin
        good_d = (good_q == LockMax) ? good_q : good_q + CW'(1);
      end else begin
        good_d = '0;
      end
    end else if (miss) begin
      good_d = '0;
    end
  end

  // A new VGA line starts whenever the next position lands on either half boundary
  assign vga_wrap = (zx_h_d == '0) || (zx_h_d == HalfLine);

  always_comb begin
    vga_v_d      = vga_v_q;
    vsync_pend_d = vs_fall | (vsync_pend_q & ~hs_fall);
    if (hs_fall && vsync_pend_q) begin
      vga_v_d = '0;
    end else if (vga_wrap && (vga_v_q != '1)) begin
      vga_v_d = vga_v_q + 10'd1;
    end
  end

  always_ff @(posedge ZX_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      zx_h_q       <= '0;
      vga_v_q      <= '0;
      good_q       <= '0;
      wr_bank_q    <= 1'b0;
      vsync_pend_q <= 1'b0;
    end else begin
      zx_h_q       <= zx_h_d;
      vga_v_q      <= vga_v_d;
      good_q       <= good_d;
      wr_bank_q    <= wr_bank_q ^ hs_fall;
      vsync_pend_q <= vsync_pend_d;
    end
  end

  assign locked = (good_q == LockMax);
  assign LOCKED = locked;
  assign half   = (zx_h_q >= HalfLine);
  assign vga_h  = half ? (zx_h_q - HalfLine) : zx_h_q;

  // Offsets wrap below the window start, so one unsigned compare bounds both ends
  logic [9:0]    cap_off, rd_off;
  logic          cap_en, in_win;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0]    pix, rd_q;
  logic [3:0]    buf_mem [2][ACTIVE_W];

  assign cap_off = zx_h_q - CapStart;
  assign cap_en  = zx_h_q[0] & (cap_off < CapLen);
  assign wr_addr = cap_off[AW:1];
  assign rd_off  = vga_h - HStart;
  assign in_win  = (rd_off < ActW);
  assign rd_addr = rd_off[AW-1:0];
  assign pix     = {ZX_R, ZX_G, ZX_B, ZX_I};

  always_ff @(posedge ZX_14M) begin
    if (cap_en) begin
      buf_mem[wr_bank_q][wr_addr] <= pix;
    end
    if (in_win) begin
      rd_q <= buf_mem[~wr_bank_q][rd_addr];
    end
  end

  // Stage 0 decode, stage 1 alongside the buffer read, stage 2 drives the pins
  logic act0, dim0, hs0, vs0;
  logic act1_q, dim1_q, hs1_q, vs1_q;
  logic ilv;

  assign act0 = locked & (vga_v_q >= VStart) & in_win;
  assign dim0 = SCANLINE & half;
  assign hs0  = ~((vga_h >= HsStart) && (vga_h < HsEnd));
  assign vs0  = ~((vga_v_q >= VsStart) && (vga_v_q < VsEnd));
  assign ilv  = rd_q[0] & ~dim1_q;

  always_ff @(posedge ZX_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      act1_q    <= 1'b0;
      dim1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      VGA_R     <= 2'b00;
      VGA_G     <= 2'b00;
      VGA_B     <= 2'b00;
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
    end else begin
      act1_q    <= act0;
      dim1_q    <= dim0;
      hs1_q     <= hs0;
      vs1_q     <= vs0;
      VGA_R     <= act1_q ? {rd_q[3], ilv} : 2'b00;
      VGA_G     <= act1_q ? {rd_q[2], ilv} : 2'b00;
      VGA_B     <= act1_q ? {rd_q[1], ilv} : 2'b00;
      VGA_HSYNC <= hs1_q;
      VGA_VSYNC <= vs1_q;
    end
  end

endmodule

// File: tb/tb_zx_line_doubler.sv
// Randomised bench for zx_line_doubler: a line-level reference model predicts every
// output pin on every clock, plus directed lock/unlock/reset checks.
module tb_zx_line_doubler;

  localparam int LineClks = 896;
  localparam int HalfLine = LineClks / 2;
  localparam int ActiveW  = 312;

  logic       ZX_14M = 1'b0;
  logic       RESET_N = 1'b1;
  logic       ZX_R = 1'b0, ZX_G = 1'b0, ZX_B = 1'b0, ZX_I = 1'b0;
  logic       ZX_HSYNC = 1'b1, ZX_VSYNC = 1'b1, SCANLINE = 1'b0;
  logic [1:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HSYNC, VGA_VSYNC, LOCKED;

  always #5 ZX_14M = ~ZX_14M;

  zx_line_doubler dut (
    .ZX_14M   (ZX_14M),
    .RESET_N  (RESET_N),
    .ZX_R     (ZX_R),
    .ZX_G     (ZX_G),
    .ZX_B     (ZX_B),
    .ZX_I     (ZX_I),
    .ZX_HSYNC (ZX_HSYNC),
    .ZX_VSYNC (ZX_VSYNC),
    .SCANLINE (SCANLINE),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .VGA_HSYNC(VGA_HSYNC),
    .VGA_VSYNC(VGA_VSYNC),
    .LOCKED   (LOCKED)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: line position, VGA line, good-line count, pending frame
  // reload, pin history for the synchroniser delay, last captured and displayed lines.
  int         m_h, m_v, m_good;
  bit         m_pend;
  logic [2:0] hs_hist, vs_hist;
  logic [3:0] cur_line  [ActiveW];
  logic [3:0] disp_line [ActiveW];
  logic [5:0] saved_pix, pin_pix;
  logic [1:0] saved_sync, pin_sync;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_good = 0; m_pend = 1'b0;
    hs_hist = 3'b111; vs_hist = 3'b111;
    saved_pix = '0; pin_pix = '0;
    saved_sync = 2'b11; pin_sync = 2'b11;
  endtask

  task automatic model_step();
    bit         ev, vev, half, in_win, act, dim, lo;
    int         vh, nh;
    logic [3:0] px;
    ev     = hs_hist[2] && !hs_hist[1];
    vev    = vs_hist[2] && !vs_hist[1];
    half   = (m_h >= HalfLine);
    vh     = m_h % HalfLine;
    in_win = (vh >= 89) && (vh < 89 + ActiveW);
    px     = in_win ? disp_line[vh - 89] : 4'h0;
    act    = (m_good == 4) && (m_v >= 109) && in_win;
    dim    = SCANLINE && half;
    lo     = px[0] && !dim;
    pin_pix    = saved_pix;
    pin_sync   = saved_sync;
    saved_pix  = act ? {px[3], lo, px[2], lo, px[1], lo} : 6'd0;
    saved_sync = {!((vh >= 10) && (vh < 62)), !((m_v >= 74) && (m_v < 76))};
    if ((m_h % 2 == 1) && (m_h >= 64) && (m_h < 64 + 2 * ActiveW))
      cur_line[(m_h - 64) / 2] = {ZX_R, ZX_G, ZX_B, ZX_I};
    if (ev) begin
      m_good = (m_h >= LineClks - 1 - 8) ? ((m_good < 4) ? m_good + 1 : 4) : 0;
      disp_line = cur_line;
      nh = 0;
    end else if (m_h == LineClks - 1) begin
      m_good = 0;
      nh = 0;
    end else begin
      nh = m_h + 1;
    end
    if (ev && m_pend) m_v = 0;
    else if ((nh % HalfLine == 0) && (m_v < 1023)) m_v = m_v + 1;
    m_pend  = vev || (m_pend && !ev);
    m_h     = nh;
    hs_hist = {hs_hist[1:0], ZX_HSYNC};
    vs_hist = {vs_hist[1:0], ZX_VSYNC};
  endtask

  task automatic tick();
    @(posedge ZX_14M);
    if (!RESET_N) model_reset();
    else model_step();
    #1;
    check("pix", {VGA_R, VGA_G, VGA_B}, pin_pix);
    check("sync", {VGA_HSYNC, VGA_VSYNC}, pin_sync);
    check("lock", LOCKED, (m_good == 4) ? 1 : 0);
  endtask

  // mode: 0 random pixels, 1 ramp with pixel 0 = 4'b1011, 2 all 4'b1111
  task automatic drive_line(input int len, input bit hs_on, input int vs_at, input int mode,
                            input bit scan, input int rst_at);
    for (int c = 0; c < len; c++) begin
      logic [3:0] px;
      ZX_HSYNC = !(hs_on && (c < 64));
      ZX_VSYNC = !((vs_at >= 0) && (c >= vs_at) && (c < vs_at + 100));
      SCANLINE = scan;
      case (mode)
        1:       px = (c >= 68) ? 4'((((c - 68) >> 1) + 11) & 15) : 4'h0;
        2:       px = 4'hF;
        default: px = 4'($urandom_range(0, 15));
      endcase
      {ZX_R, ZX_G, ZX_B, ZX_I} = px;
      if (c == rst_at) begin
        check("pre_rst_lock", LOCKED, 1);
        RESET_N = 1'b0;
        #1;
        check("rst_async", {VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, LOCKED}, 9'b000000110);
        model_reset();
      end
      if ((rst_at >= 0) && (c == rst_at + 3)) RESET_N = 1'b1;
      tick();
    end
  endtask

  initial begin
    int mode;
    bit scan;
    model_reset();
    RESET_N = 1'b0;
    repeat (4) tick();
    RESET_N = 1'b1;

    for (int l = 0; l < 61; l++) begin
      mode = (l == 54 || l == 55) ? 1 : ((l == 56 || l == 57) ? 2 : 0);
      scan = (l == 57 || l == 58) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_line(896, 1'b1, (l == 1) ? 300 : -1, mode, scan, -1);
    end

    drive_line(900, 1'b1, -1, 0, 1'b0, -1);
    check("miss_900", LOCKED, 0);
    for (int l = 0; l < 5; l++) drive_line(896, 1'b1, -1, 0, 1'($urandom_range(0, 1)), -1);
    check("relock", LOCKED, 1);
    for (int l = 0; l < 2; l++) drive_line(890, 1'b1, -1, 0, 1'b0, -1);
    check("lock_890", LOCKED, 1);

    drive_line(896, 1'b0, -1, 0, 1'b0, -1);
    check("unlock", LOCKED, 0);
    drive_line(896, 1'b0, -1, 0, 1'b0, -1);
    for (int l = 0; l < 5; l++) drive_line(896, 1'b1, -1, 0, 1'b0, -1);

    drive_line(896, 1'b1, -1, 0, 1'b0, 600);
    for (int l = 0; l < 2; l++) drive_line(896, 1'b1, -1, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
